wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 11 +
 rtl/wb_mux.sv | 15 +
 rtl/wb_regfile.sv | 94 +++++++++
 tb/tb_wb_regfile.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared sizing constants for the write-back register file and its
// write-back selection mux.
package wb_regfile_pkg;

  localparam int DATA_SIZE_DEF = 32;
  localparam int ADDR_SIZE_DEF = 5;
  localparam int REG_COUNT     = 32;
  localparam int ZERO_REG      = 0;
  localparam int CNT_WIDTH     = 32;

endpackage

// File: rtl/wb_mux.sv
// 2:1 write-back source select: load data when sel=1, ALU/link result otherwise.
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int data_size = DATA_SIZE_DEF
) (
  input  logic                 sel,
  input  logic [data_size-1:0] in0,
  input  logic [data_size-1:0] in1,
  output logic [data_size-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/wb_regfile.sv
// Register file with write-back source mux, same-cycle write->read bypass,
// hardwired zero register and a committed-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int data_size = DATA_SIZE_DEF,
  parameter int addr_size = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 WB_MemtoReg,
  input  logic                 WB_RegWrite,
  input  logic [data_size-1:0] WB_DM_Read_Data,
  input  logic [data_size-1:0] WB_WD_out,
  input  logic [addr_size-1:0] WB_WR_out,
  input  logic [addr_size-1:0] Read_addr_1,
  input  logic [addr_size-1:0] Read_addr_2,
  output logic [data_size-1:0] Read_data_1,
  output logic [data_size-1:0] Read_data_2,
  output logic [data_size-1:0] WB_Write_Data,
  output logic [31:0]          WB_Commit_Count
);

  localparam int NREGS = (addr_size == ADDR_SIZE_DEF) ? REG_COUNT : (1 << addr_size);
  localparam logic [addr_size-1:0] ZERO_IDX = addr_size'(ZERO_REG);

  logic [data_size-1:0] regs_q [NREGS];
  logic [data_size-1:0] regs_d [NREGS];
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 wr_en_s;

  wb_mux #(.data_size(data_size)) u_wb_mux (
    .sel (WB_MemtoReg),
    .in0 (WB_WD_out),
    .in1 (WB_DM_Read_Data),
    .out (WB_Write_Data)
  );

  assign wr_en_s = WB_RegWrite && (WB_WR_out != ZERO_IDX);

  // Next-state for storage and commit counter; counter wraps naturally.
  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    if (wr_en_s) begin
      regs_d[WB_WR_out] = WB_Write_Data;
      count_d           = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // State registers, cleared asynchronously so reset wins over a coincident write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end

  // Read ports: zero during reset and for r0, bypass the pending write otherwise.
  always_comb begin
    Read_data_1 = '0;
    Read_data_2 = '0;
    if (!rst) begin
      Read_data_1 = '0;
      Read_data_2 = '0;
    end else begin
      if (Read_addr_1 == ZERO_IDX) begin
        Read_data_1 = '0;
      end else if (wr_en_s && (Read_addr_1 == WB_WR_out)) begin
        Read_data_1 = WB_Write_Data;
      end else begin
        Read_data_1 = regs_q[Read_addr_1];
      end
      if (Read_addr_2 == ZERO_IDX) begin
        Read_data_2 = '0;
      end else if (wr_en_s && (Read_addr_2 == WB_WR_out)) begin
        Read_data_2 = WB_Write_Data;
      end else begin
        Read_data_2 = regs_q[Read_addr_2];
      end
    end
  end

  assign WB_Commit_Count = 32'(count_q);

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile against an array/counter model.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        mtr;
  logic        we;
  logic [31:0] dm;
  logic [31:0] wd;
  logic [4:0]  wr;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] wbd;
  logic [31:0] cnt;

  logic [31:0] model [32];
  logic [31:0] model_cnt;
  int          checks;
  int          failures;

  wb_regfile dut (
    .clk             (clk),
    .rst             (rst),
    .WB_MemtoReg     (mtr),
    .WB_RegWrite     (we),
    .WB_DM_Read_Data (dm),
    .WB_WD_out       (wd),
    .WB_WR_out       (wr),
    .Read_addr_1     (ra1),
    .Read_addr_2     (ra2),
    .Read_data_1     (rd1),
    .Read_data_2     (rd2),
    .WB_Write_Data   (wbd),
    .WB_Commit_Count (cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] exp_wdata();
    return mtr ? dm : wd;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] ra);
    if (!rst) return 32'd0;
    if (ra == 5'd0) return 32'd0;
    if (we && wr != 5'd0 && ra == wr) return exp_wdata();
    return model[ra];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model_cnt = 32'd0;
  endtask

  task automatic drive(input logic w, input logic m, input logic [31:0] d,
                       input logic [31:0] a, input logic [4:0] idx);
    we = w; mtr = m; dm = d; wd = a; wr = idx;
  endtask

  // One clock edge; the model commits what a correct register file would.
  task automatic step();
    logic [31:0] wdat;
    bit commit;
    wdat   = exp_wdata();
    commit = rst && we && (wr != 5'd0);
    @(posedge clk);
    if (commit) begin
      model[wr] = wdat;
      model_cnt = model_cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_state();
    ra1 = 5'd5; ra2 = 5'd31;
    #1;
    checks++;
    if (cnt !== 32'd0 || rd1 !== 32'd0 || rd2 !== 32'd0) begin
      failures++;
      $display("FAIL reset_state cnt=%h rd1=%h rd2=%h expected all 0", cnt, rd1, rd2);
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd7);
    step();
    we = 1'b0; ra2 = 5'd7;
    #1;
    checks++;
    if (rd2 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_read rd2=%h expected %h", rd2, 32'hDEADBEEF);
    end
    checks++;
    if (cnt !== model_cnt) begin
      failures++;
      $display("FAIL write_read_count cnt=%0d expected %0d", cnt, model_cnt);
    end
  endtask

  task automatic test_mux();
    drive(1'b1, 1'b1, 32'hA5A5A5A5, 32'h1, 5'd3);
    #1;
    checks++;
    if (wbd !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL mux_select wbd=%h expected %h", wbd, 32'hA5A5A5A5);
    end
    step();
    we = 1'b0; ra1 = 5'd3;
    #1;
    checks++;
    if (rd1 !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL mux_write rd1=%h expected %h", rd1, 32'hA5A5A5A5);
    end
  endtask

  task automatic test_r0();
    logic [31:0] cnt_before;
    cnt_before = model_cnt;
    drive(1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0);
    ra1 = 5'd0;
    #1;
    checks++;
    if (rd1 !== 32'd0) begin
      failures++;
      $display("FAIL r0_before rd1=%h expected 0", rd1);
    end
    step();
    #1;
    checks++;
    if (rd1 !== 32'd0 || cnt !== cnt_before) begin
      failures++;
      $display("FAIL r0_after rd1=%h cnt=%0d expected 0 / %0d", rd1, cnt, cnt_before);
    end
    we = 1'b0;
  endtask

  task automatic test_bypass();
    drive(1'b1, 1'b0, 32'h0, 32'h11, 5'd9);
    step();
    drive(1'b1, 1'b0, 32'h0, 32'h22, 5'd9);
    ra1 = 5'd9; ra2 = 5'd9;
    #1;
    checks++;
    if (rd1 !== 32'h22 || rd2 !== 32'h22) begin
      failures++;
      $display("FAIL bypass rd1=%h rd2=%h expected 22/22", rd1, rd2);
    end
    step();
    we = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'h22) begin
      failures++;
      $display("FAIL bypass_commit rd1=%h expected 22", rd1);
    end
  endtask

  task automatic test_regwrite0();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'($urandom), $urandom, $urandom, 5'($urandom));
      ra1 = wr; ra2 = 5'($urandom);
      step();
      #1;
      checks++;
      if (rd1 !== exp_read(ra1) || rd2 !== exp_read(ra2) || cnt !== model_cnt) begin
        failures++;
        $display("FAIL regwrite0 rd1=%h/%h rd2=%h/%h cnt=%0d/%0d (actual/expected)",
                 rd1, exp_read(ra1), rd2, exp_read(ra2), cnt, model_cnt);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom,
            5'($urandom));
      ra1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
      ra2 = 5'($urandom);
      #1;
      checks++;
      if (wbd !== exp_wdata() || rd1 !== exp_read(ra1) || rd2 !== exp_read(ra2)) begin
        failures++;
        $display("FAIL random_read it=%0d wbd=%h/%h rd1=%h/%h rd2=%h/%h (actual/expected)",
                 i, wbd, exp_wdata(), rd1, exp_read(ra1), rd2, exp_read(ra2));
      end
      step();
      #1;
      checks++;
      if (cnt !== model_cnt) begin
        failures++;
        $display("FAIL random_count it=%0d cnt=%0d expected %0d", i, cnt, model_cnt);
      end
    end
    we = 1'b0;
  endtask

  task automatic test_wrap();
    we = 1'b0;
    force dut.count_q = 32'hFFFFFFFF;
    #1;
    release dut.count_q;
    model_cnt = 32'hFFFFFFFF;
    #1;
    checks++;
    if (cnt !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL wrap_preset cnt=%h expected FFFFFFFF", cnt);
    end
    drive(1'b1, 1'b0, 32'h0, 32'h77, 5'd12);
    step();
    we = 1'b0;
    #1;
    checks++;
    if (cnt !== 32'd0 || model_cnt !== 32'd0) begin
      failures++;
      $display("FAIL wrap cnt=%h expected 0", cnt);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 32'h0, 32'h1234, 5'd5);
    step();
    ra1 = 5'd5; ra2 = 5'd5;
    #1;
    checks++;
    if (rd1 !== 32'h1234) begin
      failures++;
      $display("FAIL reset_pre rd1=%h expected 1234", rd1);
    end
    drive(1'b1, 1'b0, 32'h0, 32'h9999, 5'd5);
    #1;
    rst = 1'b0;
    clear_model();
    #1;
    checks++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0 || cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_async rd1=%h rd2=%h cnt=%0d expected 0/0/0", rd1, rd2, cnt);
    end
    drive(1'b1, 1'b0, 32'h0, 32'hAAAA, 5'd6);
    step();
    rst = 1'b1;
    we = 1'b0; ra1 = 5'd6; ra2 = 5'd5;
    #1;
    checks++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0 || cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_lost_write rd1=%h rd2=%h cnt=%0d expected 0/0/0", rd1, rd2, cnt);
    end
    drive(1'b1, 1'b1, 32'h55, 32'h0, 5'd6);
    step();
    we = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'h55 || cnt !== 32'd1) begin
      failures++;
      $display("FAIL reset_resume rd1=%h cnt=%0d expected 55/1", rd1, cnt);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    ra1 = 5'd0; ra2 = 5'd0;
    clear_model();
    repeat (2) @(negedge clk);
    test_reset_state();
    rst = 1'b1;
    @(negedge clk);
    test_write_read();
    test_mux();
    test_r0();
    test_bypass();
    test_regwrite0();
    test_random();
    test_wrap();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
